// File: rtl/piso_pkg.sv
// piso_pkg
// Shared definitions for the PISO feeder and anything that must agree with
// the downstream shifter about frame timing.
//   state_t       : frame FSM states (IDLE, SHIFT)
//   clog2w()      : counter/pointer width helper, never returns 0
//   frame_period(): cycles between loads, WIDTH + EXTRA_BITS
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width needed to hold values 0..n-1; a 1-bit minimum keeps n=1 legal.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int frame_period(input int width, input int extra_bits);
    return width + extra_bits;
  endfunction

endpackage

// File: rtl/piso_word_fifo.sv
// piso_word_fifo
// Synchronous word FIFO buffering parallel words ahead of the shifter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : word to write
//   pop         : drop the head word (ignored when empty)
//   head        : current head word, valid while !empty
//   full, empty : status, decoded from the registered occupancy only
module piso_word_fifo
  import piso_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piso_feeder.sv
// piso_feeder
// Upstream control for the parallel-in/serial-out shifter. Buffers words from
// a valid/ready stream and issues one load pulse per frame of
// P = WIDTH + EXTRA_BITS cycles, so each word is fully shifted out before the
// next one is loaded.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : permits new loads; a running frame always completes
//   in_valid   : upstream word valid
//   in_data    : upstream word
//   in_ready   : FIFO not full (registered, independent of pop/in_valid)
//   load       : one-cycle registered load pulse to the shifter
//   par_data   : word presented with load, held until the next load
//   busy       : high for every cycle of a frame's serialisation window
//   underrun   : one-cycle pulse when a frame ends with enable high and no data
module piso_feeder
  import piso_pkg::*;
#(
  parameter int WIDTH      = 50,
  parameter int EXTRA_BITS = 25,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             load,
  output logic [WIDTH-1:0] par_data,
  output logic             busy,
  output logic             underrun
);

  localparam int P     = frame_period(WIDTH, EXTRA_BITS);
  localparam int CNT_W = clog2w(P);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load_next;
  logic             busy_next;
  logic             underrun_next;
  logic [WIDTH-1:0] par_next;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  // The FIFO drops the write itself when full, so in_valid feeds push directly.
  piso_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // frame_cnt is P-1 in the load cycle and reaches 0 in the last cycle of the
  // window; the decision made there takes effect in cycle L+P, which gives
  // back-to-back loads exactly P apart (every cycle when P=1).
  always_comb begin
    state_next    = state;
    cnt_next      = frame_cnt;
    load_next     = 1'b0;
    busy_next     = busy;
    underrun_next = 1'b0;
    par_next      = par_data;
    fifo_pop      = 1'b0;

    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (enable && !fifo_empty) begin
          state_next = SHIFT;
          load_next  = 1'b1;
          busy_next  = 1'b1;
          par_next   = fifo_head;
          fifo_pop   = 1'b1;
          cnt_next   = LAST_CNT;
        end
      end
      SHIFT: begin
        if (frame_cnt != '0) begin
          cnt_next = frame_cnt - CNT_W'(1);
        end else if (enable && !fifo_empty) begin
          load_next = 1'b1;
          busy_next = 1'b1;
          par_next  = fifo_head;
          fifo_pop  = 1'b1;
          cnt_next  = LAST_CNT;
        end else begin
          state_next    = IDLE;
          busy_next     = 1'b0;
          underrun_next = enable;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      par_data  <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= cnt_next;
      load      <= load_next;
      busy      <= busy_next;
      underrun  <= underrun_next;
      par_data  <= par_next;
    end
  end

endmodule
